// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// In-order store buffer between the execute stage and the data-memory write
// port. Stores enter speculatively at the tail. The ROB commits them in order
// by advancing the commit pointer. Committed stores drain from the head, one
// per cycle, onto a registered memory write port.
//
// Optional feature macro: STORE_BUFFER_FORWARD_EN
//   defined   -> combinational store-to-load forwarding against all valid
//                entries; the youngest match wins
//   undefined -> no comparators; fwd_hit_o / fwd_data_o are tied to 0
//
// Ports:
//   clk_i, rst_n_i     clock (rising edge) / asynchronous active-low reset
//   store_valid_i      enqueue request, with store_addr_i / store_data_i
//   store_ready_o      buffer can accept an enqueue (registered state only)
//   commit_i           ROB commits the oldest uncommitted store
//   flush_i            discard all uncommitted entries
//   mem_we_o           data-memory write strobe, with mem_addr_o / mem_data_o
//   empty_o            no valid entries
//   load_addr_i        forwarding lookup address
//   fwd_hit_o          forwarding hit
//   fwd_data_o         forwarded data
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int ENTRY_NUM = 8,
  parameter int PTR_LEN   = 3,
  parameter int ADDR_LEN  = 32,
  parameter int DATA_LEN  = 32
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                store_valid_i,
  input  logic [ADDR_LEN-1:0] store_addr_i,
  input  logic [DATA_LEN-1:0] store_data_i,
  output logic                store_ready_o,
  input  logic                commit_i,
  input  logic                flush_i,
  output logic                mem_we_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_data_o,
  output logic                empty_o,
  input  logic [ADDR_LEN-1:0] load_addr_i,
  output logic                fwd_hit_o,
  output logic [DATA_LEN-1:0] fwd_data_o
);

  // Pointers carry an extra wrap bit, so full and empty can be told apart.
  logic [PTR_LEN:0]    r_head;
  logic [PTR_LEN:0]    r_cmt;
  logic [PTR_LEN:0]    r_tail;

  logic [ADDR_LEN-1:0] r_addrMem [ENTRY_NUM];
  logic [DATA_LEN-1:0] r_dataMem [ENTRY_NUM];

  logic                r_memWe;
  logic [ADDR_LEN-1:0] r_memAddr;
  logic [DATA_LEN-1:0] r_memData;

  logic [PTR_LEN:0]    w_count;
  logic [PTR_LEN:0]    w_cmtCnt;
  logic [PTR_LEN:0]    w_specCnt;
  logic                w_full;
  logic                w_enq;
  logic                w_commit;
  logic                w_drain;
  logic [PTR_LEN:0]    w_headNext;
  logic [PTR_LEN:0]    w_cmtNext;
  logic [PTR_LEN:0]    w_tailNext;
  logic                w_fwdHit;
  logic [DATA_LEN-1:0] w_fwdData;
  logic                w_unused;

  assign w_count   = r_tail - r_head;
  assign w_cmtCnt  = r_cmt - r_head;
  assign w_specCnt = r_tail - r_cmt;
  assign w_full    = (w_count == (PTR_LEN+1)'(ENTRY_NUM));

  // Ready depends only on registered occupancy. A drain in the same cycle
  // therefore does not open a slot until the next cycle.
  assign w_enq    = store_valid_i && !w_full && !flush_i;
  assign w_commit = commit_i && (w_specCnt != '0);
  assign w_drain  = (w_cmtCnt != '0);

  // A flush rewinds the tail to the commit pointer after any same-cycle
  // commit. Committed stores therefore survive, and the enqueue is dropped.
  always_comb begin
    w_headNext = r_head + (PTR_LEN+1)'(w_drain);
    w_cmtNext  = r_cmt + (PTR_LEN+1)'(w_commit);
    w_tailNext = r_tail + (PTR_LEN+1)'(w_enq);
    if (flush_i) begin
      w_tailNext = w_cmtNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head <= '0;
      r_cmt  <= '0;
      r_tail <= '0;
    end else begin
      r_head <= w_headNext;
      r_cmt  <= w_cmtNext;
      r_tail <= w_tailNext;
    end
  end

  // Entry storage is not reset. Validity comes entirely from the pointers.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_addrMem[r_tail[PTR_LEN-1:0]] <= store_addr_i;
      r_dataMem[r_tail[PTR_LEN-1:0]] <= store_data_i;
    end
  end

  // The write port is registered. The strobe drops on idle cycles, while
  // address and data keep their last value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_memWe   <= 1'b0;
      r_memAddr <= '0;
      r_memData <= '0;
    end else begin
      r_memWe <= w_drain;
      if (w_drain) begin
        r_memAddr <= r_addrMem[r_head[PTR_LEN-1:0]];
        r_memData <= r_dataMem[r_head[PTR_LEN-1:0]];
      end
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  logic [PTR_LEN:0] w_fwdPtr;

  // Walk the entries from oldest to youngest so that the youngest match
  // overwrites any older one. The head entry stays valid while it drains.
  // An enqueue this cycle is not yet inside the tail range.
  always_comb begin
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_fwdPtr  = r_head;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_fwdPtr = r_head + (PTR_LEN+1)'(i);
      if (((PTR_LEN+1)'(i) < w_count) &&
          (r_addrMem[w_fwdPtr[PTR_LEN-1:0]][ADDR_LEN-1:2] == load_addr_i[ADDR_LEN-1:2])) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_dataMem[w_fwdPtr[PTR_LEN-1:0]];
      end
    end
  end

  // Matching is per word, so the byte-offset bits play no part.
  assign w_unused = ^load_addr_i[1:0];
`else
  assign w_fwdHit  = 1'b0;
  assign w_fwdData = '0;
  assign w_unused  = ^load_addr_i;
`endif

  assign store_ready_o = !w_full;
  assign empty_o       = (w_count == '0);
  assign mem_we_o      = r_memWe;
  assign mem_addr_o    = r_memAddr;
  assign mem_data_o    = r_memData;
  assign fwd_hit_o     = w_fwdHit;
  assign fwd_data_o    = w_fwdData;

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Directed bench for store_buffer. Each scenario task drives its own stimulus
// and checks against hand-computed values. A negedge monitor records every
// memory write, so the scenarios can check the order and timing of writes.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic                store_valid_i;
  logic [ADDR_LEN-1:0] store_addr_i;
  logic [DATA_LEN-1:0] store_data_i;
  logic                store_ready_o;
  logic                commit_i;
  logic                flush_i;
  logic                mem_we_o;
  logic [ADDR_LEN-1:0] mem_addr_o;
  logic [DATA_LEN-1:0] mem_data_o;
  logic                empty_o;
  logic [ADDR_LEN-1:0] load_addr_i;
  logic                fwd_hit_o;
  logic [DATA_LEN-1:0] fwd_data_o;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;

  logic [63:0] wrQ[$];
  int          wrCyc[$];

  store_buffer #(
    .ENTRY_NUM(8), .PTR_LEN(3), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .store_valid_i(store_valid_i), .store_addr_i(store_addr_i),
    .store_data_i(store_data_i), .store_ready_o(store_ready_o),
    .commit_i(commit_i), .flush_i(flush_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .empty_o(empty_o), .load_addr_i(load_addr_i),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
  );

  // Free-running clock with a 10-unit period
  always #5 clk_i = ~clk_i;

  // Cycle stamp, used to prove that drains land on back-to-back cycles
  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  // Record every write the buffer issues while out of reset
  always @(negedge clk_i) begin
    if (rst_n_i && mem_we_o) begin
      wrQ.push_back({mem_addr_o, mem_data_o});
      wrCyc.push_back(cycleCnt);
    end
  end

  // Advance to just after the next active edge. Inputs are driven here.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearLog();
    wrQ.delete();
    wrCyc.delete();
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    store_valid_i = 1'b0; store_addr_i = '0; store_data_i = '0;
    commit_i = 1'b0; flush_i = 1'b0; load_addr_i = '0;
    #3;
    checkBit("reset mem_we", mem_we_o, 1'b0);
    checkBit("reset ready", store_ready_o, 1'b1);
    checkBit("reset empty", empty_o, 1'b1);
    checkBit("reset fwd_hit", fwd_hit_o, 1'b0);
    checks++;
    if ({mem_addr_o, mem_data_o, fwd_data_o} !== 96'h0) begin
      errors++;
      $display("[TB] FAIL reset buses: got %h expected 0", {mem_addr_o, mem_data_o, fwd_data_o});
    end
    step(); step();
    rst_n_i = 1'b1;
    step();
  endtask

  task automatic test_single();
    clearLog();
    store_valid_i = 1'b1; store_addr_i = 32'h100; store_data_i = 32'hAAAA0001;
    step();
    store_valid_i = 1'b0; commit_i = 1'b1;
    checkBit("single empty after enq", empty_o, 1'b0);
    step();
    commit_i = 1'b0;
    checkBit("single no write on commit edge", mem_we_o, 1'b0);
    step();
    checkBit("single write one cycle after commit", mem_we_o, 1'b1);
    checks++;
    if ({mem_addr_o, mem_data_o} !== {32'h100, 32'hAAAA0001}) begin
      errors++;
      $display("[TB] FAIL single addr/data: got %h expected %h", {mem_addr_o, mem_data_o}, {32'h100, 32'hAAAA0001});
    end
    checkBit("single empty after drain", empty_o, 1'b1);
    step();
    checkBit("single strobe drops", mem_we_o, 1'b0);
    checks++;
    if (mem_addr_o !== 32'h100) begin
      errors++;
      $display("[TB] FAIL single addr hold: got %h expected %h", mem_addr_o, 32'h100);
    end
  endtask

  task automatic test_full();
    clearLog();
    for (int i = 0; i < 8; i++) begin
      store_valid_i = 1'b1; store_addr_i = 32'h400 + 4 * i; store_data_i = 32'h40 + i;
      step();
    end
    checkBit("full ready low after 8", store_ready_o, 1'b0);
    checkBit("full not empty", empty_o, 1'b0);
    checkBit("full no write", mem_we_o, 1'b0);
    store_addr_i = 32'h4F0; store_data_i = 32'hDEAD;
    step();
    store_valid_i = 1'b0;
    checkBit("full 9th rejected", store_ready_o, 1'b0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checkBit("full flush empties", empty_o, 1'b1);
    checkBit("full flush ready", store_ready_o, 1'b1);
    step();
    checks++;
    if (wrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL full writes: got %0d expected 0", wrQ.size());
    end
  endtask

  task automatic test_flush_partial();
    clearLog();
    for (int i = 0; i < 4; i++) begin
      store_valid_i = 1'b1; store_addr_i = 32'h300 + 4 * i; store_data_i = 32'h30 + i;
      step();
    end
    store_valid_i = 1'b0;
    commit_i = 1'b1; step(); step();
    commit_i = 1'b0; flush_i = 1'b1; step();
    flush_i = 1'b0;
    checkBit("partial ready after flush", store_ready_o, 1'b1);
    step(); step(); step();
    checkBit("partial empty after drains", empty_o, 1'b1);
    checks++;
    if (wrQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL partial write count: got %0d expected 2", wrQ.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wrQ[i] !== {32'h300 + 32'(4 * i), 32'h30 + 32'(i)}) begin
          errors++;
          $display("[TB] FAIL partial write %0d: got %h expected %h", i, wrQ[i], {32'h300 + 32'(4 * i), 32'h30 + 32'(i)});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clearLog();
    for (int i = 0; i < 21; i++) begin
      store_valid_i = (i < 20);
      store_addr_i = 32'(4 * i); store_data_i = 32'(i);
      commit_i = 1'b1;
      step();
    end
    store_valid_i = 1'b0; commit_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checkBit("b2b empty", empty_o, 1'b1);
    checks++;
    if (wrQ.size() != 20) begin
      errors++;
      $display("[TB] FAIL b2b write count: got %0d expected 20", wrQ.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (wrQ[i] !== {32'(4 * i), 32'(i)} || wrCyc[i] != wrCyc[0] + i) begin
          errors++;
          $display("[TB] FAIL b2b write %0d: got %h at cycle %0d expected %h at cycle %0d",
                   i, wrQ[i], wrCyc[i], {32'(4 * i), 32'(i)}, wrCyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_flush_commit_enq();
    clearLog();
    for (int i = 0; i < 3; i++) begin
      store_valid_i = 1'b1; store_addr_i = 32'h500 + 4 * i; store_data_i = 32'h50 + i;
      step();
    end
    store_addr_i = 32'h600; store_data_i = 32'h99;
    commit_i = 1'b1; flush_i = 1'b1;
    step();
    store_valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
    checkBit("fce committed entry kept", empty_o, 1'b0);
    for (int i = 0; i < 4; i++) step();
    checkBit("fce empty at end", empty_o, 1'b1);
    checks++;
    if (wrQ.size() != 1 || wrQ[0] !== {32'h500, 32'h50}) begin
      errors++;
      $display("[TB] FAIL fce writes: got %0d writes first %h expected 1 write %h",
               wrQ.size(), (wrQ.size() > 0) ? wrQ[0] : 64'h0, {32'h500, 32'h50});
    end
  endtask

  task automatic test_forward();
    clearLog();
    store_valid_i = 1'b1; store_addr_i = 32'h200; store_data_i = 32'h11;
    step();
    store_data_i = 32'h22;
    step();
    store_valid_i = 1'b0;
    load_addr_i = 32'h200;
    #1;
`ifdef STORE_BUFFER_FORWARD_EN
    checkBit("fwd hit 0x200", fwd_hit_o, 1'b1);
    checks++;
    if (fwd_data_o !== 32'h22) begin
      errors++;
      $display("[TB] FAIL fwd youngest data: got %h expected %h", fwd_data_o, 32'h22);
    end
    load_addr_i = 32'h202;
    #1;
    checkBit("fwd hit same word", fwd_hit_o, 1'b1);
    load_addr_i = 32'h204;
    #1;
    checkBit("fwd miss 0x204", fwd_hit_o, 1'b0);
`else
    checkBit("fwd tied hit", fwd_hit_o, 1'b0);
    checks++;
    if (fwd_data_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL fwd tied data: got %h expected 0", fwd_data_o);
    end
`endif
    load_addr_i = '0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checkBit("fwd cleanup empty", empty_o, 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      store_valid_i = 1'b1; store_addr_i = 32'h700 + 4 * i; store_data_i = 32'h70 + i;
      step();
    end
    store_valid_i = 1'b0; commit_i = 1'b1;
    step(); step();
    checkBit("mid first write issued", mem_we_o, 1'b1);
    rst_n_i = 1'b0;
    clearLog();
    #1;
    commit_i = 1'b0;
    checkBit("mid reset kills strobe", mem_we_o, 1'b0);
    checkBit("mid reset empty", empty_o, 1'b1);
    step(); step();
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (wrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid writes after reset: got %0d expected 0", wrQ.size());
    end
  endtask

  initial begin
    $display("[TB] store_buffer bench start");
    test_reset();
    test_single();
    test_full();
    test_flush_partial();
    test_back_to_back();
    test_flush_commit_enq();
    test_forward();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
In-order store buffer that holds speculative stores from the execute stage until the ROB commits them. It then drains committed stores, one per cycle, into the data-memory write port (address/data/write-enable). The block is the writer-side partner of the data-memory BRAM. Loads use the memory's read port, and with the optional feature they can forward from pending stores.

Parameters:
ENTRY_NUM, 8, number of buffer entries; power of two, at least 2
PTR_LEN, 3, log2(ENTRY_NUM)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_n_i  input  1  asynchronous active-low reset
store_valid_i  input  1  enqueue request from execute stage
store_addr_i  input  ADDR_LEN  store byte address
store_data_i  input  DATA_LEN  store data
store_ready_o  output  1  buffer can accept an enqueue this cycle
commit_i  input  1  ROB commits the oldest uncommitted store
flush_i  input  1  branch mispredict; discard all uncommitted entries
mem_we_o  output  1  write strobe to data memory
mem_addr_o  output  ADDR_LEN  write address to data memory
mem_data_o  output  DATA_LEN  write data to data memory
empty_o  output  1  no valid entries
load_addr_i  input  ADDR_LEN  load lookup address (used only with feature)
fwd_hit_o  output  1  forwarding hit (feature only, else tied 0)
fwd_data_o  output  DATA_LEN  forwarded data (feature only, else tied 0)

Behaviour:
- State is a circular array of {addr, data}, plus head_ptr (oldest), cmt_ptr (oldest uncommitted) and tail_ptr (next free). Each pointer is PTR_LEN+1 bits; the MSB is the wrap bit.
- Counts: count = tail-head; cmt_cnt = cmt_ptr-head; spec_cnt = tail-cmt_ptr.
- Full is count==ENTRY_NUM. store_ready_o = !full, computed from registered state only. A drain in the same cycle does not free a slot for that cycle.
- Enqueue happens when store_valid_i && store_ready_o && !flush_i. The entry is written at tail and tail increments. store_valid_i while full is dropped; the producer must hold it.
- Commit: commit_i with spec_cnt>0 advances cmt_ptr by 1. commit_i with spec_cnt==0 is ignored.
- Flush: tail_ptr <= cmt_ptr, after applying any same-cycle commit. An enqueue in the flush cycle is dropped. Committed entries are never discarded.
- Drain: when cmt_cnt>0, the head entry is registered onto mem_addr_o/mem_data_o with mem_we_o=1 next cycle, and head increments.
  - One drain per cycle.
  - Latency: an entry committed in cycle N gives mem_we_o=1 in cycle N+1 at the earliest.
  - mem_we_o is 0 on any cycle with no drain. mem_addr_o/mem_data_o hold their last value.
- Simultaneous enqueue, commit and drain in one cycle are all legal and independent. The pointer arithmetic must be consistent.
- Wrap-around: pointers wrap modulo 2*ENTRY_NUM. Entry index is ptr[PTR_LEN-1:0].
- empty_o = (count==0), from registered state.
- Reset (asynchronous, rst_n_i=0) clears all pointers. Reset values:
  - mem_we_o=0, mem_addr_o=0, mem_data_o=0
  - store_ready_o=1, empty_o=1
  - fwd_hit_o=0, fwd_data_o=0
- Entry contents need not be reset.
- Reset mid-drain aborts immediately; no further writes occur.

Optional Feature:
STORE_BUFFER_FORWARD_EN.
- Defined: combinational lookup of load_addr_i[ADDR_LEN-1:2] against all valid entries (committed and uncommitted).
  - fwd_hit_o=1 on any match.
  - fwd_data_o is the data of the youngest match, nearest tail.
  - An entry being drained this cycle still counts as valid.
  - An entry enqueued this cycle does not count.
- Undefined: no comparators. fwd_hit_o and fwd_data_o are tied 0. load_addr_i is unused.

Test Plan:
- Reset, then enqueue {0x100, 0xAAAA0001} and commit it next cycle -> mem_we_o=1 with addr 0x100 and data 0xAAAA0001 exactly one cycle after the commit; empty_o=1 afterwards.
- Enqueue 8 stores with no commits -> store_ready_o=0 after the 8th; a 9th store_valid_i is not accepted; empty_o=0; mem_we_o stays 0.
- Enqueue 4, commit 2, then flush_i -> exactly 2 writes reach memory in order; tail returns to cmt_ptr; store_ready_o=1; empty_o=1 after the drains.
- Continuous enqueue+commit for 20 stores (addr 0x0..0x4C, data = i) -> 20 writes in order, each mem_we_o one per cycle, no loss across pointer wrap.
- Flush in the same cycle as commit_i and store_valid_i with 3 spec entries -> 1 entry committed, 2 discarded, new store dropped.
- With STORE_BUFFER_FORWARD_EN: two pending stores to 0x200 with data 0x11 then 0x22, load_addr_i=0x200 -> fwd_hit_o=1 and fwd_data_o=0x22. load_addr_i=0x204 -> fwd_hit_o=0.
